// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned CLKS_PER_BIT_DEF = 20;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pad; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   // Double-register the pad to settle metastability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver, LSB first, mid-bit sampling from a fixed clock divider.
// Optional feature: define UART_RX_SYNC_EN to pass RX_data through a 2-flop synchronizer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX_data,
   output logic [7:0] Received_byte,
   output logic       receive_state,
   output logic       error
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS);

   logic                 rx;
   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;

`ifdef UART_RX_SYNC_EN
   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (RX_data),
      .q   (rx)
   );
`else
   assign rx = RX_data;
`endif

   // Next-state: frame FSM, bit timer, bit index, shift register and result registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx) state_d = START;
         end
         START: begin
            if (cnt_q == CW'(HALF_BIT - 1)) begin
               cnt_d = '0;
               if (!rx) begin
                  state_d = DATA;
                  err_d   = 1'b0;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE; // glitch, not a start bit
               end
            end
         end
         DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx;
               if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
               else                             idx_d   = idx_q + IW'(1);
            end
         end
         STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (rx) begin
                  byte_d  = shift_q;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx) state_d = IDLE; // line must go high before a new frame
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign Received_byte = byte_q;
   assign receive_state = busy_q;
   assign error         = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random frames, framing errors, glitches and resets,
// with a scoreboard checked whenever a frame (or false start) ends.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB = 20;

   typedef struct {
      logic [7:0] b;
      logic       e;
      bit         glitch;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       RX_data;
   logic [7:0] Received_byte;
   logic       receive_state;
   logic       error;

   int         n_tests = 0;
   int         n_fail  = 0;
   exp_t       exp_q[$];
   logic [7:0] last_byte = 8'h00;
   logic       last_err  = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .rst           (rst),
      .RX_data       (RX_data),
      .Received_byte (Received_byte),
      .receive_state (receive_state),
      .error         (error)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      RX_data = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Full frame; a bad stop bit holds the line low for 'hold' more cycles before releasing.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold);
      exp_t e;
      int   seen;
      if (stop_ok) begin
         last_byte = d;
         last_err  = 1'b0;
      end else begin
         last_err  = 1'b1;
      end
      e.b = last_byte;
      e.e = last_err;
      e.glitch = 1'b0;
      exp_q.push_back(e);
      RX_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX_data = d[i];
         repeat (CPB) @(negedge clk);
      end
      RX_data = stop_ok;
      repeat (CPB) @(negedge clk);
      if (!stop_ok) begin
         seen = 0;
         repeat (hold) begin
            @(negedge clk);
            if (receive_state) seen = 1;
         end
         chk("break_no_restart", seen, 0);
         RX_data = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic send_glitch(input int k);
      exp_t e;
      e.b = last_byte;
      e.e = last_err;
      e.glitch = 1'b1;
      exp_q.push_back(e);
      RX_data = 1'b0;
      repeat (k) @(negedge clk);
      idle(CPB);
   endtask

   // Scoreboard monitor: each falling edge of receive_state ends a frame or a false start.
   initial begin
      bit   prev;
      int   hi_len;
      exp_t e;
      prev   = 1'b0;
      hi_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev   = 1'b0;
            hi_len = 0;
         end else begin
            if (receive_state) hi_len++;
            if (prev && !receive_state) begin
               chk("expected_pending", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rx_byte", Received_byte, e.b);
                  chk("rx_error", error, e.e);
                  if (e.glitch) chk("busy_len_glitch", (hi_len >= 5 && hi_len <= 13), 1);
                  else          chk("busy_len_frame", (hi_len >= 185 && hi_len <= 193), 1);
               end
               hi_len = 0;
            end
            prev = receive_state;
         end
      end
   end

   initial begin
      int         w;
      int         r;
      logic [7:0] d;
      rst     = 1'b1;
      RX_data = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_byte", Received_byte, 8'h00);
      chk("reset_busy", receive_state, 0);
      chk("reset_error", error, 0);
      rst = 1'b0;
      idle(60);
      chk("idle_byte", Received_byte, 8'h00);
      chk("idle_busy", receive_state, 0);
      chk("idle_error", error, 0);

      send_frame(8'h55, 1'b1, 0);
      idle(10);
      send_frame(8'h85, 1'b0, 100);
      chk("err_frame_byte_kept", Received_byte, 8'h55);
      chk("err_frame_flag", error, 1);
      idle(20);
      send_frame(8'hA3, 1'b1, 0);
      idle(10);
      send_glitch(10);
      idle(10);

      // Reset in the middle of the data bits.
      RX_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         RX_data = i[0];
         repeat (CPB) @(negedge clk);
      end
      #5 rst = 1'b1;
      #1;
      chk("midreset_byte", Received_byte, 8'h00);
      chk("midreset_busy", receive_state, 0);
      chk("midreset_error", error, 0);
      last_byte = 8'h00;
      last_err  = 1'b0;
      RX_data   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(10);
      send_frame(8'h3C, 1'b1, 0);

      for (int n = 0; n < 40; n++) begin
         idle($urandom_range(1, 30));
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         if (r < 7)      send_frame(d, 1'b1, 0);
         else if (r < 9) send_frame(d, 1'b0, $urandom_range(5, 60));
         else            send_glitch($urandom_range(1, 8));
      end
      idle(20);

      w = 0;
      while (exp_q.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
